mem_noc_router_ot: RTL and testbench

Single-master, multi-slave memory NoC router with multiple outstanding transactions. It decodes each `mem_req_t` address to one of `DEC_NUM` slave ports and forwards the request in zero cycles. It records the selected port in an in-order route FIFO and steers responses back strictly in request order. It replaces the single-outstanding router between the core-side memory master and the memory/peripheral slaves, so back-to-back requests no longer stall on the response.

---
 rtl/mem_noc_router_ot.sv | 157 +++++++++++++++
 tb/tb_mem_noc_router_ot.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_noc_router_ot.sv
// rtl/mem_noc_router_ot.sv - in-order multi-outstanding memory NoC router (1 master, DEC_NUM slaves)

package mem_noc_pkg;

  typedef struct packed {
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_write;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_last;
  } mem_resp_t;

endpackage

module mem_noc_router_ot
  import mem_noc_pkg::*;
#(
  parameter int          DEC_NUM        = 4,
  parameter bit          ENABLE_DEC_TAG = 1'b0,
  parameter bit          ENABLE_DEC_IDX = 1'b1,
  parameter int          DEC_TAG_H      = 31,
  parameter int          DEC_TAG_L      = 16,
  parameter int          DEC_IDX_H      = 15,
  parameter int          DEC_IDX_L      = 12,
  parameter logic [31:0] DEC_TAG_VAL    = 32'h0,
  parameter int          OT_DEPTH       = 4,
  parameter int          PORT_W         = $clog2(DEC_NUM),
  parameter int          CNT_W          = $clog2(OT_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mn_req_valid,
  output logic               mn_req_ready,
  input  mem_req_t           mn_req,
  output logic               mn_resp_valid,
  input  logic               mn_resp_ready,
  output mem_resp_t          mn_resp,
  output logic [DEC_NUM-1:0] sn_req_valid,
  input  logic [DEC_NUM-1:0] sn_req_ready,
  output mem_req_t           sn_req [DEC_NUM],
  input  logic [DEC_NUM-1:0] sn_resp_valid,
  output logic [DEC_NUM-1:0] sn_resp_ready,
  input  mem_resp_t          sn_resp [DEC_NUM],
  output logic [CNT_W-1:0]   ot_cnt,
  output logic               idle
);

  localparam int TAG_W = DEC_TAG_H - DEC_TAG_L + 1;
  localparam int IDX_W = DEC_IDX_H - DEC_IDX_L + 1;
  localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;

  // Route FIFO: one binary port id per outstanding request, oldest at r_rptr
  logic [PORT_W-1:0] r_route [OT_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_ot_cnt;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [PORT_W-1:0]  w_dec_id;
  logic [DEC_NUM-1:0] w_sel;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [PORT_W-1:0]  w_head;
  logic [PTR_W-1:0]   w_wptr_nxt;
  logic [PTR_W-1:0]   w_rptr_nxt;

  assign w_tag = mn_req.req_addr[DEC_TAG_H:DEC_TAG_L];
  assign w_idx = mn_req.req_addr[DEC_IDX_H:DEC_IDX_L];

  // Address decode: index picks the port (top port absorbs the rest), tag miss forces the top port
  always_comb begin
    w_dec_id = '0;
    if (ENABLE_DEC_IDX) begin
      if (int'(w_idx) >= DEC_NUM - 1) begin
        w_dec_id = PORT_W'(DEC_NUM - 1);
      end else begin
        w_dec_id = PORT_W'(w_idx);
      end
    end
    if (ENABLE_DEC_TAG && (w_tag != TAG_W'(DEC_TAG_VAL))) begin
      w_dec_id = PORT_W'(DEC_NUM - 1);
    end
  end

  assign w_sel   = DEC_NUM'(1) << w_dec_id;
  assign w_full  = (r_ot_cnt == CNT_W'(OT_DEPTH));
  assign w_empty = (r_ot_cnt == '0);

  // Request path: broadcast payload, gate valid by the decoded port and FIFO space
  always_comb begin
    for (int i = 0; i < DEC_NUM; i++) begin
      sn_req[i] = mn_req;
    end
    sn_req_valid = (mn_req_valid && !w_full) ? w_sel : '0;
    mn_req_ready = !w_full && (|(w_sel & sn_req_ready));
  end

  assign w_push = mn_req_valid && mn_req_ready;
  assign w_head = r_route[r_rptr];

  // Response path: only the oldest outstanding port is connected; others are held off
  always_comb begin
    mn_resp_valid = 1'b0;
    mn_resp       = '0;
    sn_resp_ready = '0;
    if (!w_empty) begin
      mn_resp_valid         = sn_resp_valid[w_head];
      mn_resp               = sn_resp[w_head];
      sn_resp_ready[w_head] = mn_resp_ready;
    end
  end

  assign w_pop = mn_resp_valid && mn_resp_ready && mn_resp.resp_last;

  assign w_wptr_nxt = (r_wptr == PTR_W'(OT_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
  assign w_rptr_nxt = (r_rptr == PTR_W'(OT_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);

  // FIFO write, pointer wrap and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ot_cnt <= '0;
      for (int i = 0; i < OT_DEPTH; i++) begin
        r_route[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_route[r_wptr] <= w_dec_id;
        r_wptr          <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      if (w_push && !w_pop) begin
        r_ot_cnt <= r_ot_cnt + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_ot_cnt <= r_ot_cnt - CNT_W'(1);
      end
    end
  end

  assign ot_cnt = r_ot_cnt;
  assign idle   = w_empty;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(w_pop && w_empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_mem_noc_router_ot.sv
// tb/tb_mem_noc_router_ot.sv - randomized self-checking bench for mem_noc_router_ot
module tb_mem_noc_router_ot;
  import mem_noc_pkg::*;

  localparam int DEC_NUM  = 4;
  localparam int OT_DEPTH = 3;
  localparam int CNT_W    = $clog2(OT_DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic mn_req_valid;
  logic mn_req_ready;
  mem_req_t mn_req;
  logic mn_resp_valid;
  logic mn_resp_ready;
  mem_resp_t mn_resp;
  logic [DEC_NUM-1:0] sn_req_valid;
  logic [DEC_NUM-1:0] sn_req_ready;
  mem_req_t sn_req [DEC_NUM];
  logic [DEC_NUM-1:0] sn_resp_valid;
  logic [DEC_NUM-1:0] sn_resp_ready;
  mem_resp_t sn_resp [DEC_NUM];
  logic [CNT_W-1:0] ot_cnt;
  logic idle;

  always #5 clk = ~clk;

  mem_noc_router_ot #(
    .DEC_NUM (DEC_NUM),
    .OT_DEPTH(OT_DEPTH)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mn_req_valid (mn_req_valid),
    .mn_req_ready (mn_req_ready),
    .mn_req       (mn_req),
    .mn_resp_valid(mn_resp_valid),
    .mn_resp_ready(mn_resp_ready),
    .mn_resp      (mn_resp),
    .sn_req_valid (sn_req_valid),
    .sn_req_ready (sn_req_ready),
    .sn_req       (sn_req),
    .sn_resp_valid(sn_resp_valid),
    .sn_resp_ready(sn_resp_ready),
    .sn_resp      (sn_resp),
    .ot_cnt       (ot_cnt),
    .idle         (idle)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: outstanding requests in issue order, and each slave's pending work
  int route_q [$];
  int id_q [$];
  int slv_q [DEC_NUM][$];
  int slv_beat [DEC_NUM];
  int next_id = 1;

  int req_pct  = 70;
  int resp_pct = 60;
  int srdy_pct = 70;
  int svld_pct = 60;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_port(input logic [31:0] addr);
    int idx;
    idx = int'(addr[15:12]);
    if (idx >= DEC_NUM - 1) return DEC_NUM - 1;
    return idx;
  endfunction

  function automatic int n_beats(input int id);
    return (id % 4) + 1;
  endfunction

  task automatic drive_slaves();
    for (int i = 0; i < DEC_NUM; i++) begin
      logic [31:0] junk;
      int          id;
      junk = $urandom();
      if (slv_q[i].size() > 0 && $urandom_range(0, 99) < svld_pct) begin
        id = slv_q[i][0];
        sn_resp_valid[i]         = 1'b1;
        sn_resp[i].resp_rdata    = {id[15:0], slv_beat[i][15:0]};
        sn_resp[i].resp_err      = id[0];
        sn_resp[i].resp_last     = (slv_beat[i] == n_beats(id) - 1);
      end else begin
        sn_resp_valid[i]         = 1'b0;
        sn_resp[i].resp_rdata    = junk;
        sn_resp[i].resp_err      = junk[0];
        sn_resp[i].resp_last     = junk[1];
      end
    end
  endtask

  task automatic drive_random();
    logic [31:0] addr;
    logic [31:0] rnd;
    addr        = $urandom();
    addr[15:12] = 4'($urandom_range(0, 5));
    rnd         = $urandom();
    mn_req_valid       = ($urandom_range(0, 99) < req_pct);
    mn_req.req_addr    = addr;
    mn_req.req_wdata   = next_id;
    mn_req.req_be      = rnd[3:0];
    mn_req.req_write   = rnd[4];
    for (int i = 0; i < DEC_NUM; i++) begin
      sn_req_ready[i] = ($urandom_range(0, 99) < srdy_pct);
    end
    mn_resp_ready = ($urandom_range(0, 99) < resp_pct);
    drive_slaves();
  endtask

  // Compare all outputs at the falling edge, then advance the model across the rising edge
  task automatic step();
    logic [DEC_NUM-1:0] e_sel;
    logic [DEC_NUM-1:0] e_sreq_v;
    logic [DEC_NUM-1:0] e_sresp_r;
    logic               e_full;
    logic               e_rdy;
    logic               e_rv;
    mem_resp_t          e_resp;
    int                 p;
    int                 h;
    logic               push;
    logic               beat;
    logic               pop;
    logic [31:0]        hid;
    @(negedge clk);
    e_full   = (route_q.size() == OT_DEPTH);
    p        = ref_port(mn_req.req_addr);
    e_sel    = '0;
    e_sel[p] = 1'b1;
    e_sreq_v = (mn_req_valid && !e_full) ? e_sel : '0;
    e_rdy    = !e_full && sn_req_ready[p];
    h         = 0;
    e_rv      = 1'b0;
    e_resp    = '0;
    e_sresp_r = '0;
    if (route_q.size() > 0) begin
      h      = route_q[0];
      e_rv   = sn_resp_valid[h];
      e_resp = sn_resp[h];
      if (mn_resp_ready) e_sresp_r[h] = 1'b1;
    end
    check_val("sn_req_valid", sn_req_valid, e_sreq_v);
    check_val("mn_req_ready", mn_req_ready, e_rdy);
    check_val("sn_req_fwd", sn_req[p], mn_req);
    check_val("mn_resp_valid", mn_resp_valid, e_rv);
    check_val("mn_resp", mn_resp, e_resp);
    check_val("sn_resp_ready", sn_resp_ready, e_sresp_r);
    check_val("ot_cnt", ot_cnt, route_q.size());
    check_val("idle", idle, route_q.size() == 0);
    push = mn_req_valid && e_rdy;
    beat = e_rv && mn_resp_ready;
    pop  = beat && e_resp.resp_last;
    if (beat) begin
      hid = id_q[0];
      check_val("resp_order", mn_resp.resp_rdata[31:16], hid[15:0]);
    end
    @(posedge clk);
    #1;
    if (beat) begin
      if (pop) begin
        void'(slv_q[h].pop_front());
        slv_beat[h] = 0;
        void'(route_q.pop_front());
        void'(id_q.pop_front());
      end else begin
        slv_beat[h]++;
      end
    end
    if (push) begin
      route_q.push_back(p);
      id_q.push_back(next_id);
      slv_q[p].push_back(next_id);
      next_id++;
    end
  endtask

  task automatic run_phase(input int n, input int rq, input int rs, input int sr, input int sv);
    req_pct  = rq;
    resp_pct = rs;
    srdy_pct = sr;
    svld_pct = sv;
    repeat (n) begin
      drive_random();
      step();
    end
  endtask

  task automatic clear_model();
    route_q.delete();
    id_q.delete();
    for (int i = 0; i < DEC_NUM; i++) begin
      slv_q[i].delete();
      slv_beat[i] = 0;
    end
  endtask

  logic [31:0]        dec_addr [3];
  logic [DEC_NUM-1:0] dec_exp [3];

  initial begin
    rst           = 1'b1;
    mn_req_valid  = 1'b0;
    mn_req        = '0;
    sn_req_ready  = '0;
    mn_resp_ready = 1'b0;
    sn_resp_valid = '0;
    for (int i = 0; i < DEC_NUM; i++) begin
      sn_resp[i]  = '0;
      slv_beat[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ot_cnt", ot_cnt, 0);
    check_val("rst_idle", idle, 1);
    check_val("rst_mn_resp_valid", mn_resp_valid, 0);
    check_val("rst_sn_resp_ready", sn_resp_ready, 0);
    check_val("rst_sn_req_valid", sn_req_valid, 0);
    check_val("rst_mn_req_ready", mn_req_ready, 0);
    rst = 1'b0;

    // Directed decode of the three index boundaries
    dec_addr[0] = 32'h0000_1000;
    dec_addr[1] = 32'h0000_2000;
    dec_addr[2] = 32'h0000_F000;
    dec_exp[0]  = 4'b0010;
    dec_exp[1]  = 4'b0100;
    dec_exp[2]  = 4'b1000;
    svld_pct    = 0;
    for (int k = 0; k < 3; k++) begin
      mn_req_valid     = 1'b1;
      mn_req.req_addr  = dec_addr[k];
      mn_req.req_wdata = next_id;
      sn_req_ready     = '1;
      mn_resp_ready    = 1'b0;
      drive_slaves();
      #1;
      check_val("dec_sel", sn_req_valid, dec_exp[k]);
      step();
    end
    mn_req_valid    = 1'b1;
    mn_req.req_addr = 32'h0000_0000;
    drive_slaves();
    #1;
    check_val("full_blocks_valid", sn_req_valid, 0);
    check_val("full_blocks_ready", mn_req_ready, 0);
    step();

    run_phase(600, 90, 30, 80, 60);
    run_phase(800, 70, 70, 70, 60);
    run_phase(400, 50, 90, 90, 90);

    // Reset with at least two requests in flight
    req_pct  = 100;
    resp_pct = 0;
    srdy_pct = 100;
    svld_pct = 0;
    for (int t = 0; t < 40 && route_q.size() < 2; t++) begin
      drive_random();
      step();
    end
    check_val("fill_before_rst", route_q.size() >= 2, 1);
    mn_req_valid  = 1'b0;
    mn_resp_ready = 1'b1;
    svld_pct      = 100;
    drive_slaves();
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_ot_cnt", ot_cnt, 0);
    check_val("midrst_idle", idle, 1);
    check_val("midrst_mn_resp_valid", mn_resp_valid, 0);
    check_val("midrst_sn_resp_ready", sn_resp_ready, 0);
    clear_model();
    drive_slaves();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_phase(500, 70, 60, 70, 70);
    run_phase(200, 0, 100, 100, 100);
    check_val("final_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
